vending_controller: RTL

Sequencing controller for the vending machine credit path. Accepts coin pulses, accumulates credit in nickel units (0–12, i.e. 0–60 cents) and drives the 4-bit credit value consumed by the display decoders. Handles purchase and cancel requests, issues a one-cycle dispense strobe and returns change one nickel per cycle.

---
 rtl/vending_controller.sv | 119 +++++++++++
 1 files changed

// File: rtl/vending_controller.sv
// Vending credit sequencer: coin accumulation, vend, nickel-at-a-time change return.
// Latency 1 cycle (registered outputs); no backpressure, coins arriving when not acceptable are rejected.
module vending_controller #(
  parameter int unsigned PRICE      = 7,
  parameter int unsigned MAX_CREDIT = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  input  logic       buy,
  input  logic       cancel,
  output logic [3:0] credit,
  output logic       dispense,
  output logic       nickel_out,
  output logic       reject,
  output logic       short,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_REFUND = 2'd3
  } state_t;

  localparam logic [3:0] PRICE_C = 4'(PRICE);
  localparam logic [4:0] MAX_C   = 5'(MAX_CREDIT);

  state_t     state_q,  state_d;
  logic [3:0] credit_q, credit_d;
  logic       reject_q, reject_d;
  logic       short_q,  short_d;

  logic       coin_vld;
  logic [2:0] coin_val;
  logic [4:0] coin_sum;

  // Quarter wins over dime wins over nickel; lower coins are dropped silently.
  always_comb begin
    coin_val = 3'd0;
    if (quarter)   coin_val = 3'd5;
    else if (dime) coin_val = 3'd2;
    else if (nickel) coin_val = 3'd1;
    coin_vld = quarter | dime | nickel;
    coin_sum = {1'b0, credit_q} + {2'b00, coin_val};
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    short_d  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (state_q == ST_CREDIT && cancel) begin
          state_d  = ST_REFUND;
          reject_d = coin_vld;
        end else if (state_q == ST_CREDIT && buy && credit_q >= PRICE_C) begin
          state_d  = ST_VEND;
          credit_d = credit_q - PRICE_C;
          reject_d = coin_vld;
        end else begin
          // A refused buy is not acted on, so a coin in that cycle is still taken.
          short_d = (state_q == ST_CREDIT) && buy;
          if (coin_vld) begin
            if (coin_sum <= MAX_C) begin
              credit_d = coin_sum[3:0];
              state_d  = ST_CREDIT;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
      end
      ST_VEND: begin
        reject_d = coin_vld;
        state_d  = (credit_q != 4'd0) ? ST_REFUND : ST_IDLE;
      end
      ST_REFUND: begin
        reject_d = coin_vld;
        if (credit_q <= 4'd1) begin
          credit_d = 4'd0;
          state_d  = ST_IDLE;
        end else begin
          credit_d = credit_q - 4'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      credit_q <= 4'd0;
      reject_q <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
      short_q  <= short_d;
    end
  end

  assign credit     = credit_q;
  assign reject     = reject_q;
  assign short      = short_q;
  assign dispense   = (state_q == ST_VEND);
  assign nickel_out = (state_q == ST_REFUND);
  assign busy       = (state_q == ST_VEND) || (state_q == ST_REFUND);

endmodule
